// File: rtl/bfs_spill_pkg.sv
// -----------------------------------------------------------------------------
// bfs_spill_pkg
// Shared constants for the BFS queue spill/restore arbiter.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - spill/restore op encoding
//   - line shift (64-byte lines) and the queue-side q_op burst code
// No ports: imported by the arbiter top and its region sub-module.
// -----------------------------------------------------------------------------
package bfs_spill_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WBURST = 3'd2;
  localparam logic [2:0] S_RWAIT  = 3'd3;
  localparam logic [2:0] S_RBURST = 3'd4;

  localparam logic OP_SPILL   = 1'b0;
  localparam logic OP_RESTORE = 1'b1;

  localparam int LINE_SHIFT = 6;

  localparam logic [1:0] Q_OP_BURST = 2'b01;
  localparam logic [1:0] Q_OP_NONE  = 2'b00;

endpackage

// File: rtl/bfs_spill_arbiter_if.sv
// -----------------------------------------------------------------------------
// bfs_spill_arbiter_if
// Memory-side request/data port shared by all spill queues.
//   mem_req/mem_op/mem_addr : line command, held until mem_ready
//   mem_wvalid/mem_wdata    : write beats (no backpressure)
//   mem_rvalid/mem_rdata    : read beats
// master = arbiter side, slave = memory / L2 side.
// -----------------------------------------------------------------------------
interface bfs_spill_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_wvalid;
  logic [63:0]       mem_wdata;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;

  modport master (
    output mem_req, mem_op, mem_addr, mem_wvalid, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_op, mem_addr, mem_wvalid, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/bfs_spill_region.sv
// -----------------------------------------------------------------------------
// bfs_spill_region
// Bookkeeping for one queue's circular spill region: head, tail and line count.
//   clk, bfs_rst : clock, synchronous active-high reset
//   i_inc        : one line spilled (tail++, count++)
//   i_dec        : one line restored (head++, count--)
//   o_full       : count == SPILL_LINES
//   o_empty      : count == 0
//   o_head/o_tail: line index inside the region (wraps naturally, power of 2)
// -----------------------------------------------------------------------------
module bfs_spill_region #(
  parameter  int SPILL_LINES = 16,
  localparam int PTR_W       = $clog2(SPILL_LINES)
) (
  input  logic             clk,
  input  logic             bfs_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W-1:0] o_head,
  output logic [PTR_W-1:0] o_tail
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  // One extra bit so a completely full region is distinguishable from empty.
  logic [PTR_W:0]   r_count;

  // Pointer and occupancy update; the arbiter never strobes inc and dec together.
  always_ff @(posedge clk) begin
    if (bfs_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_inc) begin
        r_tail  <= r_tail + PTR_W'(1);
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (i_dec) begin
        r_head  <= r_head + PTR_W'(1);
        r_count <= r_count - (PTR_W+1)'(1);
      end else begin
        r_head  <= r_head;
        r_tail  <= r_tail;
        r_count <= r_count;
      end
    end
  end

  assign o_full  = (r_count == (PTR_W+1)'(SPILL_LINES));
  assign o_empty = (r_count == (PTR_W+1)'(0));
  assign o_head  = r_head;
  assign o_tail  = r_tail;

endmodule

// File: rtl/bfs_spill_arbiter.sv
// -----------------------------------------------------------------------------
// bfs_spill_arbiter
// Shares one memory port among NQ BFS queues for 64-byte line spill/restore.
// Each queue owns a circular region of SPILL_LINES lines starting at
// SPILL_BASE + q*SPILL_LINES*64.
//   clk, bfs_rst    : clock, synchronous active-high reset
//   i_q_spill_req   : per-queue request pulse (sampled only while offered)
//   i_q_spill_op    : per-queue op, 0=spill 1=restore
//   i_q_spill_data  : per-queue spill beat, queue i at [64i+63:64i]
//   o_q_ready       : one-hot accept offer (token holder, if eligible)
//   o_q_fs          : one-hot first-beat strobe
//   o_q_op          : 2'b01 while a burst is active
//   o_q_rdata       : restore beat, shared by all queues
//   o_q_rbuf_empty  : per-queue "nothing spilled and no restore in flight"
//   o_busy          : FSM not idle
//   mem             : memory command/data port (master side)
// -----------------------------------------------------------------------------
module bfs_spill_arbiter
  import bfs_spill_pkg::*;
#(
  parameter int                NQ          = 4,
  parameter int                BURST       = 8,
  parameter int                SPILL_LINES = 16,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] SPILL_BASE  = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               bfs_rst,
  input  logic [NQ-1:0]      i_q_spill_req,
  input  logic [NQ-1:0]      i_q_spill_op,
  input  logic [NQ*64-1:0]   i_q_spill_data,
  output logic [NQ-1:0]      o_q_ready,
  output logic [NQ-1:0]      o_q_fs,
  output logic [1:0]         o_q_op,
  output logic [63:0]        o_q_rdata,
  output logic [NQ-1:0]      o_q_rbuf_empty,
  output logic               o_busy,
  bfs_spill_arbiter_if.master mem
);

  localparam int GW    = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int PTR_W = $clog2(SPILL_LINES);
  localparam int BW    = $clog2(BURST);

  logic [2:0]    r_state;
  logic [NQ-1:0] r_token;
  logic [GW-1:0] r_grant;
  logic          r_op;
  logic [BW-1:0] r_beat;

  logic [NQ-1:0]    w_full;
  logic [NQ-1:0]    w_empty;
  logic [PTR_W-1:0] w_head [NQ];
  logic [PTR_W-1:0] w_tail [NQ];
  logic [NQ-1:0]    w_inc;
  logic [NQ-1:0]    w_dec;
  logic [NQ-1:0]    w_elig;
  logic [NQ-1:0]    w_ready;
  logic             w_accept;
  logic [GW-1:0]    w_tok_idx;
  logic [NQ-1:0]    w_tok_rot;
  logic [NQ-1:0]    w_grant_oh;
  logic [NQ-1:0]    w_after_grant;
  logic [NQ-1:0]    w_rflight;
  logic             w_last_beat;
  logic [PTR_W-1:0] w_ptr;
  logic [GW+PTR_W-1:0] w_line;
  logic [ADDR_W-1:0]   w_addr;

  logic              w_mem_req;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_wvalid;
  logic [63:0]       w_mem_wdata;

  for (genvar gi = 0; gi < NQ; gi++) begin : g_region
    bfs_spill_region #(.SPILL_LINES(SPILL_LINES)) u_region (
      .clk     (clk),
      .bfs_rst (bfs_rst),
      .i_inc   (w_inc[gi]),
      .i_dec   (w_dec[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi]),
      .o_head  (w_head[gi]),
      .o_tail  (w_tail[gi])
    );
  end

  assign w_tok_rot     = {r_token[NQ-2:0], r_token[NQ-1]};
  assign w_grant_oh    = NQ'(1) << r_grant;
  assign w_after_grant = {w_grant_oh[NQ-2:0], w_grant_oh[NQ-1]};
  assign w_last_beat   = (r_beat == BW'(BURST-1));

  // Eligibility: a spill needs room in the region, a restore needs a line in it.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NQ; i++) begin
      if (i_q_spill_op[i] == OP_RESTORE) begin
        w_elig[i] = ~w_empty[i];
      end else begin
        w_elig[i] = ~w_full[i];
      end
    end
  end

  // Binary index of the token holder (token is one-hot).
  always_comb begin
    w_tok_idx = '0;
    for (int i = 0; i < NQ; i++) begin
      if (r_token[i]) begin
        w_tok_idx = GW'(i);
      end else begin
        w_tok_idx = w_tok_idx;
      end
    end
  end

  assign w_ready  = (r_state == S_IDLE) ? (r_token & w_elig) : '0;
  assign w_accept = |(w_ready & i_q_spill_req);

  // Region bookkeeping moves at command acceptance, not at data completion.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if ((r_state == S_ISSUE) && mem.mem_ready) begin
      if (r_op == OP_RESTORE) begin
        w_dec = w_grant_oh;
      end else begin
        w_inc = w_grant_oh;
      end
    end else begin
      w_inc = '0;
      w_dec = '0;
    end
  end

  // Region base is a power of two, so g*SPILL_LINES + ptr is a concatenation.
  assign w_ptr  = (r_op == OP_RESTORE) ? w_head[r_grant] : w_tail[r_grant];
  assign w_line = {r_grant, w_ptr};
  assign w_addr = SPILL_BASE + (ADDR_W'(w_line) << LINE_SHIFT);

  // Sequencer: token rotation, grant capture and burst beat counting.
  always_ff @(posedge clk) begin
    if (bfs_rst) begin
      r_state <= S_IDLE;
      r_token <= NQ'(1);
      r_grant <= '0;
      r_op    <= OP_SPILL;
      r_beat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_grant <= w_tok_idx;
            r_op    <= i_q_spill_op[w_tok_idx];
            r_state <= S_ISSUE;
          end else begin
            r_token <= w_tok_rot;
          end
        end
        S_ISSUE: begin
          if (mem.mem_ready) begin
            r_beat  <= '0;
            r_state <= (r_op == OP_RESTORE) ? S_RWAIT : S_WBURST;
          end
        end
        S_RWAIT: begin
          // The first read beat is consumed here, so RBURST starts at beat 1.
          if (mem.mem_rvalid) begin
            r_beat  <= BW'(1);
            r_state <= S_RBURST;
          end
        end
        S_WBURST, S_RBURST: begin
          if (w_last_beat) begin
            r_beat  <= '0;
            r_token <= w_after_grant;
            r_state <= S_IDLE;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Queue-side and memory-side outputs decoded from the current state.
  always_comb begin
    o_q_fs       = '0;
    o_q_op       = Q_OP_NONE;
    o_q_rdata    = 64'h0;
    w_mem_req    = 1'b0;
    w_mem_addr   = '0;
    w_mem_wvalid = 1'b0;
    w_mem_wdata  = 64'h0;
    case (r_state)
      S_ISSUE: begin
        w_mem_req  = 1'b1;
        w_mem_addr = w_addr;
      end
      S_WBURST: begin
        o_q_op       = Q_OP_BURST;
        w_mem_wvalid = 1'b1;
        w_mem_wdata  = i_q_spill_data[r_grant*64 +: 64];
        o_q_fs       = (r_beat == BW'(0)) ? w_grant_oh : '0;
      end
      S_RWAIT: begin
        o_q_op = Q_OP_BURST;
        if (mem.mem_rvalid) begin
          o_q_fs    = w_grant_oh;
          o_q_rdata = mem.mem_rdata;
        end else begin
          o_q_fs    = '0;
          o_q_rdata = 64'h0;
        end
      end
      S_RBURST: begin
        o_q_op    = Q_OP_BURST;
        o_q_rdata = mem.mem_rdata;
      end
      default: begin
        o_q_fs = '0;
      end
    endcase
  end

  // A restore counts as in flight from acceptance to its last beat.
  assign w_rflight = ((r_state != S_IDLE) && (r_op == OP_RESTORE)) ? w_grant_oh : '0;

  assign o_q_ready      = w_ready;
  assign o_q_rbuf_empty = w_empty & ~w_rflight;
  assign o_busy         = (r_state != S_IDLE);

  assign mem.mem_req    = w_mem_req;
  assign mem.mem_op     = r_op;
  assign mem.mem_addr   = w_mem_addr;
  assign mem.mem_wvalid = w_mem_wvalid;
  assign mem.mem_wdata  = w_mem_wdata;

endmodule

// File: doc/bfs_spill_arbiter.md
Name: bfs_spill_arbiter

Overview:
Shares one memory port among NQ BFS queue instances for queue spill and restore bursts. Each spilled 64-byte line is written to a private circular region per queue. The block sequences command issue and the 8-beat data stream to and from memory. It drives each queue's cache-side handshake (ready, first-beat strobe, op, read data, buffer-empty) and sits between the queue array and the L2/memory request port.

Parameters:
NQ, 4, number of queue requesters.
BURST, 8, 64-bit beats per line; fixed by the queue's 1+7 beat sequence.
SPILL_LINES, 16, lines per queue spill region; power of 2.
ADDR_W, 32, memory byte-address width.
SPILL_BASE, 32'h8000_0000, base byte address of the spill area.

Ports:
clk  in  1  clock; single clock domain
bfs_rst  in  1  synchronous, active-high reset
q_spill_req  in  NQ  per-queue request pulse, sampled only while q_ready[i]=1
q_spill_op  in  NQ  per-queue op, valid whenever that queue is pending: 0=spill, 1=restore
q_spill_data  in  NQ*64  per-queue spill beat; queue i occupies bits [64i+63:64i]
q_ready  out  NQ  one-hot accept offer (queue's dc_ready)
q_fs  out  NQ  one-hot first-beat strobe (queue's dc_fs)
q_op  out  2  2'b01 while a burst is active, else 2'b00
q_rdata  out  64  restore beat, shared by all queues
q_rbuf_empty  out  NQ  1 = no spilled lines in memory and no restore in flight for that queue
mem_req  out  1  command valid
mem_op  out  1  0=write line, 1=read line
mem_addr  out  ADDR_W  line-aligned byte address
mem_ready  in  1  command accepted this cycle
mem_wvalid  out  1  write beat valid
mem_wdata  out  64  write beat
mem_rvalid  in  1  read beat valid
mem_rdata  in  64  read beat
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, bfs_rst=1): state=IDLE, token=queue 0, all head/tail/count=0, beat counter=0. Reset overrides everything, including an abort mid-burst; no memory cleanup is performed. Reset output values: q_ready=0001 (assuming queue 0 is eligible), q_fs=0, q_op=0, mem_req=0, mem_wvalid=0, q_rbuf_empty=all 1, busy=0.
- Token: a one-hot rotating pointer.
  - In IDLE with no acceptance, the token advances by one every cycle (wraps from NQ-1 to 0).
  - After a burst completes, the token moves to the queue after the one just served.
- Eligibility and offer:
  - Queue i is eligible unless (op=spill and count_i==SPILL_LINES) or (op=restore and count_i==0).
  - q_ready[i] = (state==IDLE) & token[i] & eligible_i. The offer is combinational on q_spill_op.
  - If a queue is ineligible, the token still rotates past it.
- Accept: q_ready[i] & q_spill_req[i] latches grant g=i and op, then moves to ISSUE on the next cycle.
- Address: mem_addr = SPILL_BASE + ((g*SPILL_LINES + ptr) << 6).
  - ptr is tail_g for a spill and head_g for a restore.
  - The region index wraps modulo SPILL_LINES.
- States:
  - IDLE: offers ready as above; on accept -> ISSUE.
  - ISSUE: mem_req=1 with mem_op and mem_addr held until mem_ready.
    - On mem_ready for a spill: tail_g++, count_g++; -> WBURST.
    - On mem_ready for a restore: head_g++, count_g--; -> RWAIT.
  - WBURST: 8 consecutive cycles; q_fs[g]=1 in the first cycle only.
    - mem_wvalid=1 and mem_wdata=q_spill_data[g], combinational, same cycle.
    - The memory accepts write beats with no backpressure.
    - After beat 7 -> IDLE.
  - RWAIT: waits for mem_rvalid. On the first mem_rvalid: q_fs[g]=1, q_rdata=mem_rdata; -> RBURST.
  - RBURST: 7 more beats, forwarded combinationally to q_rdata. mem_rvalid is required high on each of these 7 cycles, because the queue enqueues unconditionally. After beat 7 -> IDLE.
- q_op=2'b01 in WBURST, RWAIT and RBURST; 2'b00 otherwise.
- q_rbuf_empty[i] = (count_i==0) & ~(restore in flight for i, from accept through the last beat).
  - For a spill, count increments at command accept, so rbuf_empty falls before the data lands.
- Simultaneous events: only one queue can be offered per cycle, so requests never collide. Request pulses outside an offer are ignored.
- Latency: accept -> mem_req next cycle. Spill: mem_ready -> first q_fs next cycle. Restore: first q_fs in the same cycle as the first mem_rvalid.

Decomposition:
- bfs_spill_pkg:
  - state encoding: IDLE, ISSUE, WBURST, RWAIT, RBURST
  - OP_SPILL=0, OP_RESTORE=1
  - LINE_SHIFT=6
  - Q_OP_BURST=2'b01
- Sub-module bfs_spill_region, instantiated NQ times:
  - holds head, tail and count for one queue
  - takes inc/dec strobes
  - outputs full, empty, head and tail

Test Plan:
- Single spill, NQ=4, queue 2, token at 0:
  - q_ready[2] rises at cycle 2; mem_addr=8000_0800, mem_op=0.
  - 8 wvalid beats carrying data 0..7 match mem_wdata; q_fs[2] high on beat 0 only.
  - Afterwards count_2=1 and q_rbuf_empty[2]=0.
- Restore after the spill:
  - Drive 8 rvalid beats A0..A7. q_fs[2] is high with q_rdata=A0, and A1..A7 follow.
  - q_rbuf_empty[2] returns to 1 after the last beat; head_2=1.
- Wrap-around: 17 spills plus 17 restores on queue 0.
  - The 17th spill address is 8000_0000 again; the 17th restore reads 8000_0000.
- Full region: 16 spills on queue 1, then a spill request.
  - q_ready[1] stays 0 and the token rotates past queue 1.
  - A restore request from queue 1 is accepted.
- Contention: queues 0 and 3 both pending.
  - Served in token order 0 then 3; token ends at 0.
  - mem_ready held low for 5 cycles keeps mem_req and mem_addr stable.
- Reset at WBURST beat 4:
  - The next cycle shows busy=0 and mem_wvalid=0.
  - All q_rbuf_empty=1 and q_ready returns to 0001.
